mult_div_ctrl: RTL and testbench

MULT_DIV_CTRL -- requirements
Module: mult_div_ctrl

---
 rtl/mult_div_ctrl.sv | 146 ++++++++++++++
 tb/tb_mult_div_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mult_div_ctrl.sv
// Iterative MIPS-style HI/LO multiply/divide unit: radix-2 shift-add multiply,
// restoring divide, 35-cycle fixed latency, 2-cycle divide-by-zero.
module mult_div_ctrl #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [1:0]        i_op,
  input  logic [DATA_W-1:0] i_rs_data,
  input  logic [DATA_W-1:0] i_rt_data,
  input  logic              i_mthi,
  input  logic              i_mtlo,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_div_zero,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  localparam int unsigned CNT_W  = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t              state_q, state_d;
  logic [1:0]          op_q;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [PROD_W-1:0]   p_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                res_neg_q, rem_neg_q;

  logic                accept, is_div, signed_op, a_neg, b_neg, div_by_zero;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     add_sum, shifted, diff;
  logic [PROD_W-1:0]   mul_next, div_next, prod_fix;
  logic [DATA_W-1:0]   quo, rem, quo_fix, rem_fix, hi_fix, lo_fix;

  // Operand sign handling and one iteration of each algorithm.
  always_comb begin
    is_div      = op_q[1];
    signed_op   = op_q[0];
    a_neg       = signed_op & a_q[DATA_W-1];
    b_neg       = signed_op & b_q[DATA_W-1];
    a_mag       = a_neg ? DATA_W'('0 - a_q) : a_q;
    b_mag       = b_neg ? DATA_W'('0 - b_q) : b_q;
    div_by_zero = is_div && (b_q == '0);

    add_sum  = {1'b0, p_q[PROD_W-1:DATA_W]} + (p_q[0] ? {1'b0, a_q} : '0);
    mul_next = {add_sum, p_q[DATA_W-1:1]};

    // p_q holds {remainder, dividend/quotient shift register} while dividing
    shifted  = {p_q[PROD_W-1:DATA_W], p_q[DATA_W-1]};
    diff     = shifted - {1'b0, b_q};
    div_next = diff[DATA_W] ? {shifted[DATA_W-1:0], p_q[DATA_W-2:0], 1'b0}
                            : {diff[DATA_W-1:0],    p_q[DATA_W-2:0], 1'b1};

    quo      = p_q[DATA_W-1:0];
    rem      = p_q[PROD_W-1:DATA_W];
    prod_fix = res_neg_q ? PROD_W'('0 - p_q) : p_q;
    quo_fix  = res_neg_q ? DATA_W'('0 - quo) : quo;
    rem_fix  = rem_neg_q ? DATA_W'('0 - rem) : rem;
    hi_fix   = is_div ? rem_fix : prod_fix[PROD_W-1:DATA_W];
    lo_fix   = is_div ? quo_fix : prod_fix[DATA_W-1:0];
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    accept  = i_start && ((state_q == IDLE) || (state_q == DONE));
    case (state_q)
      IDLE:    if (accept) state_d = PREP;
      PREP:    state_d = div_by_zero ? DONE : CALC;
      CALC:    if (cnt_q == CNT_LAST) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = accept ? PREP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_div_zero <= 1'b0;
    end else begin
      state_q    <= state_d;
      o_busy     <= (state_d == PREP) || (state_d == CALC) || (state_d == FIX);
      o_done     <= (state_d == DONE);
      o_div_zero <= (state_q == PREP) && div_by_zero;
    end
  end

  // Operand, accumulator and counter datapath.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (accept) begin
            op_q <= i_op;
            a_q  <= i_rs_data;
            b_q  <= i_rt_data;
          end
        end
        PREP: begin
          a_q       <= a_mag;
          b_q       <= b_mag;
          res_neg_q <= a_neg ^ b_neg;
          rem_neg_q <= a_neg;
          cnt_q     <= '0;
          p_q       <= is_div ? {{DATA_W{1'b0}}, a_mag} : {{DATA_W{1'b0}}, b_mag};
        end
        CALC: begin
          p_q   <= is_div ? div_next : mul_next;
          cnt_q <= cnt_q + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // HI/LO: software moves only while idle; results land on leaving FIX.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_hi <= '0;
      o_lo <= '0;
    end else if (state_q == FIX) begin
      o_hi <= hi_fix;
      o_lo <= lo_fix;
    end else if (!o_busy) begin
      if (i_mthi) o_hi <= i_rs_data;
      if (i_mtlo) o_lo <= i_rs_data;
    end
  end

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Randomized bench for mult_div_ctrl: a latency/arithmetic reference model is
// compared every cycle, plus directed literal cases.
module tb_mult_div_ctrl;

  logic        clk = 1'b0;
  logic        rst, start, mthi, mtlo;
  logic [1:0]  op;
  logic [31:0] rs, rt;
  logic        busy, done, dz;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  bit armed  = 0;

  always #5 clk = ~clk;

  mult_div_ctrl #(.DATA_W(32)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_op(op),
    .i_rs_data(rs), .i_rt_data(rt), .i_mthi(mthi), .i_mtlo(mtlo),
    .o_busy(busy), .o_done(done), .o_div_zero(dz), .o_hi(hi), .o_lo(lo)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural result {HI, LO} straight from integer arithmetic.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, sq, sr;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'd0: p = {32'd0, a} * {32'd0, b};
      2'd1: p = 64'(sa * sb);
      2'd2: p = {a % b, a / b};
      default: begin
        sq = sa / sb;
        sr = sa % sb;
        p  = {32'(sr), 32'(sq)};
      end
    endcase
    return p;
  endfunction

  // Reference model: an accepted op completes after a fixed number of edges.
  logic        m_busy = 0, m_done = 0, m_dz = 0, m_zero = 0;
  logic [31:0] m_hi = 0, m_lo = 0;
  logic [63:0] m_res = 0;
  int          m_timer = 0;

  always @(posedge clk) begin
    logic ob;
    if (rst) begin
      m_busy = 0; m_done = 0; m_dz = 0; m_hi = 0; m_lo = 0; m_timer = 0;
    end else begin
      ob = m_busy;
      m_done = 0;
      m_dz   = 0;
      if (!ob && mthi) m_hi = rs;
      if (!ob && mtlo) m_lo = rs;
      if (ob) begin
        m_timer--;
        if (m_timer == 0) begin
          m_busy = 0;
          m_done = 1;
          if (m_zero) m_dz = 1;
          else {m_hi, m_lo} = m_res;
        end
      end
      if (start && !ob) begin
        m_zero  = op[1] && (rt == 32'd0);
        m_res   = m_zero ? 64'd0 : ref_result(op, rs, rt);
        m_timer = m_zero ? 1 : 34;
        m_busy  = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      check("busy", 64'(busy), 64'(m_busy));
      check("done", 64'(done), 64'(m_done));
      check("div_zero", 64'(dz), 64'(m_dz));
      check("hi", 64'(hi), 64'(m_hi));
      check("lo", 64'(lo), 64'(m_lo));
    end
  end

  // Launch one op; optionally poke start+mthi or reset at a given cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int poke, input int rstc, output int lat, output logic dzs);
    bit seen = 0;
    lat = 0;
    dzs = 0;
    @(negedge clk);
    start = 1; op = o; rs = a; rt = b;
    for (int n = 1; n <= 60; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 0; op = 2'($urandom); rs = $urandom; rt = $urandom;
      end
      if (n == poke) begin start = 1; mthi = 1; end
      if (n == poke + 1) begin start = 0; mthi = 0; end
      if (n == rstc + 1 && rstc > 0) begin
        rst = 0;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
      end
      if (n == rstc) rst = 1;
      if (done) begin
        seen = 1;
        lat  = n;
        dzs  = dz;
        if (rstc == 0) break;
      end
    end
    start = 0; mthi = 0; rst = 0;
    if (rstc > 0) check("rst_no_done", 64'(seen), 64'd0);
    else if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int lat, d1, d2;
    logic dzs;
    rst = 1; start = 0; mthi = 0; mtlo = 0; op = 0; rs = 0; rt = 0;
    repeat (2) @(negedge clk);
    armed = 1;
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    rst = 0;

    run_op(2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, lat, dzs);
    check("multu_lat", 64'(lat), 64'd35);
    check("multu_res", {hi, lo}, 64'hFFFFFFFE_00000001);

    run_op(2'd1, 32'hFFFFFFFD, 32'h5, 0, 0, lat, dzs);
    check("mult_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);

    run_op(2'd3, 32'hFFFFFFF9, 32'h2, 0, 0, lat, dzs);
    check("div_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    run_op(2'd3, 32'h80000000, 32'hFFFFFFFF, 0, 0, lat, dzs);
    check("div_wrap", {hi, lo}, 64'h00000000_80000000);

    @(negedge clk); mthi = 1; rs = 32'h12345678;
    @(negedge clk); mthi = 0; mtlo = 1; rs = 32'h9ABCDEF0;
    @(negedge clk); mtlo = 0;
    check("mthi_mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
    run_op(2'd2, 32'd100, 32'd0, 0, 0, lat, dzs);
    check("dz_lat", 64'(lat), 64'd2);
    check("dz_flag", 64'(dzs), 64'd1);
    check("dz_keep", {hi, lo}, 64'h12345678_9ABCDEF0);

    run_op(2'd2, 32'd1000, 32'd7, 10, 0, lat, dzs);
    check("poke_lat", 64'(lat), 64'd35);
    check("poke_res", {hi, lo}, 64'h00000006_0000008E);

    run_op(2'd0, 32'h1234, 32'h5678, 0, 10, lat, dzs);

    // Back-to-back: start held high across DONE.
    d1 = 0; d2 = 0;
    @(negedge clk); start = 1; op = 2'd1; rs = 32'd7; rt = 32'hFFFFFFFE;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (done && d1 == 0) d1 = n;
      else if (done) begin d2 = n; start = 0; break; end
    end
    start = 0;
    check("b2b_gap", 64'(d2 - d1), 64'd35);
    check("b2b_res", {hi, lo}, 64'hFFFFFFFF_FFFFFFF2);

    // Random traffic checked by the model.
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      start = ($urandom_range(7) == 0);
      op    = 2'($urandom);
      rs    = ($urandom_range(5) == 0) ? 32'h80000000 : $urandom;
      rt    = ($urandom_range(7) == 0) ? 32'd0 :
              ($urandom_range(7) == 0) ? 32'hFFFFFFFF : $urandom;
      mthi  = ($urandom_range(15) == 0);
      mtlo  = ($urandom_range(15) == 0);
      rst   = ($urandom_range(499) == 0);
    end
    @(negedge clk);
    start = 0; mthi = 0; mtlo = 0; rst = 0;
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
